tactile_frame_buffer: RTL

Single-clock, double-buffered frame store for the tactile sensor matrix. It sits between the ADC scan sequencer and the readout/display logic. ADC samples are written into a ping-pong frame bank while the reader sees only the last complete frame. A capturable baseline frame lets reads return baseline-subtracted, zero-clamped pressure values.

---
 rtl/tactile_pkg.sv | 21 ++
 rtl/tactile_sdp_ram.sv | 32 +++
 rtl/tactile_frame_buffer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/tactile_pkg.sv
// Shared types and helpers for the tactile sensor frame buffer.
// Holds the baseline FSM state type and the point address mapping.
package tactile_pkg;

    localparam int unsigned FRAME_SEQ_W = 16;

    typedef enum logic [1:0] {
        BL_IDLE    = 2'd0,
        BL_ARMED   = 2'd1,
        BL_CAPTURE = 2'd2
    } bl_state_t;

    function automatic int unsigned point_addr(
        input int unsigned sw,
        input int unsigned rd,
        input int unsigned rd_wire_cnt
    );
        return sw * rd_wire_cnt + rd;
    endfunction

endpackage

// File: rtl/tactile_sdp_ram.sv
// Single-clock simple dual-port RAM with registered, read-first output.
// Uninitialised and never reset, so it maps onto block RAM.
module tactile_sdp_ram #(
    parameter  int unsigned WIDTH = 12,
    parameter  int unsigned DEPTH = 256,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Non-blocking read and write on the same edge return the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/tactile_frame_buffer.sv
// Ping-pong frame store for the tactile matrix with an optional captured
// baseline frame subtracted (and clamped at zero) on the read path.
module tactile_frame_buffer
    import tactile_pkg::*;
#(
    parameter  int unsigned SW_WIRE_CNT = 16,
    parameter  int unsigned RD_WIRE_CNT = 16,
    parameter  int unsigned DATA_WIDTH  = 12,
    localparam int unsigned DEPTH       = SW_WIRE_CNT * RD_WIRE_CNT,
    localparam int unsigned AW          = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [$clog2(SW_WIRE_CNT)-1:0] sw_idx_in,
    input  logic [$clog2(RD_WIRE_CNT)-1:0] rd_idx_in,
    input  logic [DATA_WIDTH-1:0]          data_in,
    input  logic                           data_valid_in,
    input  logic                           frame_end_in,
    input  logic                           baseline_capture_in,
    input  logic                           sub_en_in,
    input  logic                           read_req_in,
    input  logic [AW-1:0]                  read_addr,
    output logic [DATA_WIDTH-1:0]          data_out,
    output logic                           data_valid_out,
    output logic                           frame_ready_out,
    output logic [FRAME_SEQ_W-1:0]         frame_seq_out,
    output logic                           baseline_valid_out,
    output logic                           error_out
);

    localparam int unsigned CNT_W = AW + 2;

    logic [AW:0]             wr_addr_full;
    logic                    idx_bad;
    logic                    wr_accept;
    logic                    bl_we;
    logic [DATA_WIDTH-1:0]   frame_rd;
    logic [DATA_WIDTH-1:0]   base_rd;
    logic signed [DATA_WIDTH:0] diff;
    logic [CNT_W-1:0]        cnt_incl;

    logic                    wr_bank_q, wr_bank_d;
    logic                    rd_bank_q, rd_bank_d;
    logic [CNT_W-1:0]        pt_cnt_q, pt_cnt_d;
    logic [FRAME_SEQ_W-1:0]  frame_seq_q, frame_seq_d;
    logic                    frame_ready_q, frame_ready_d;
    logic                    error_q, error_d;
    bl_state_t               bl_state_q, bl_state_d;
    logic                    bl_valid_q, bl_valid_d;
    logic                    req1_q, req1_d;
    logic                    sub1_q, sub1_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic                    dvalid_q, dvalid_d;

    assign wr_addr_full = (AW + 1)'(point_addr(32'(sw_idx_in), 32'(rd_idx_in), RD_WIRE_CNT));
    assign idx_bad      = (32'(sw_idx_in) >= SW_WIRE_CNT) || (32'(rd_idx_in) >= RD_WIRE_CNT)
                       || (32'(wr_addr_full) >= DEPTH);
    assign wr_accept    = data_valid_in && !idx_bad;
    assign bl_we        = wr_accept && (bl_state_q == BL_CAPTURE);

    tactile_sdp_ram #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (2 * DEPTH)
    ) u_frame_ram (
        .clk   (clk),
        .we    (wr_accept),
        .waddr ({wr_bank_q, wr_addr_full[AW-1:0]}),
        .wdata (data_in),
        .re    (read_req_in),
        .raddr ({rd_bank_q, read_addr}),
        .rdata (frame_rd)
    );

    tactile_sdp_ram #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_base_ram (
        .clk   (clk),
        .we    (bl_we),
        .waddr (wr_addr_full[AW-1:0]),
        .wdata (data_in),
        .re    (read_req_in),
        .raddr (read_addr),
        .rdata (base_rd)
    );

    // Write side: point count, bank swap, frame sequence and error flag.
    always_comb begin
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        frame_seq_d   = frame_seq_q;
        frame_ready_d = 1'b0;
        error_d       = error_q;

        cnt_incl = pt_cnt_q;
        if (wr_accept && (pt_cnt_q != '1)) begin
            cnt_incl = pt_cnt_q + 1'b1;
        end
        pt_cnt_d = cnt_incl;

        if (data_valid_in && idx_bad) begin
            error_d = 1'b1;
        end

        if (frame_end_in) begin
            wr_bank_d     = ~wr_bank_q;
            rd_bank_d     = ~rd_bank_q;
            frame_seq_d   = frame_seq_q + 1'b1;
            frame_ready_d = 1'b1;
            pt_cnt_d      = '0;
            if (cnt_incl != CNT_W'(DEPTH)) begin
                error_d = 1'b1;
            end
        end
    end

    always_comb begin
        bl_state_d = bl_state_q;
        bl_valid_d = bl_valid_q;
        case (bl_state_q)
            BL_IDLE:    if (baseline_capture_in) bl_state_d = BL_ARMED;
            BL_ARMED:   if (frame_end_in) bl_state_d = BL_CAPTURE;
            BL_CAPTURE: begin
                if (frame_end_in) begin
                    bl_state_d = BL_IDLE;
                    bl_valid_d = 1'b1;
                end
            end
            default:    bl_state_d = BL_IDLE;
        endcase
    end

    // The RAM output registers form the sampling stage; request and
    // sub_en ride alongside them so a later bank swap cannot disturb them.
    always_comb begin
        req1_d     = read_req_in;
        sub1_d     = sub_en_in;
        dvalid_d   = req1_q;
        data_out_d = data_out_q;
        diff       = $signed({1'b0, frame_rd}) - $signed({1'b0, base_rd});
        if (req1_q) begin
            if (sub1_q && bl_valid_q) begin
                data_out_d = diff[DATA_WIDTH] ? '0 : diff[DATA_WIDTH-1:0];
            end else begin
                data_out_d = frame_rd;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b1;
            pt_cnt_q      <= '0;
            frame_seq_q   <= '0;
            frame_ready_q <= 1'b0;
            error_q       <= 1'b0;
            bl_state_q    <= BL_IDLE;
            bl_valid_q    <= 1'b0;
            req1_q        <= 1'b0;
            sub1_q        <= 1'b0;
            data_out_q    <= '0;
            dvalid_q      <= 1'b0;
        end else begin
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            pt_cnt_q      <= pt_cnt_d;
            frame_seq_q   <= frame_seq_d;
            frame_ready_q <= frame_ready_d;
            error_q       <= error_d;
            bl_state_q    <= bl_state_d;
            bl_valid_q    <= bl_valid_d;
            req1_q        <= req1_d;
            sub1_q        <= sub1_d;
            data_out_q    <= data_out_d;
            dvalid_q      <= dvalid_d;
        end
    end

    assign data_out           = data_out_q;
    assign data_valid_out     = dvalid_q;
    assign frame_ready_out    = frame_ready_q;
    assign frame_seq_out      = frame_seq_q;
    assign baseline_valid_out = bl_valid_q;
    assign error_out          = error_q;

endmodule
